// File: rtl/arbitro_param.sv
// Arbiter that moves FIFO head words from NUM_PORTS x NUM_VC sources to NUM_OUT registered outputs.
// The destination sits in the top bits of each word. MODE 0 gives strict VC priority, MODE 1 a flat round-robin.
module arbitro_param #(
   parameter int DATA_W    = 6,
   parameter int NUM_PORTS = 2,
   parameter int NUM_VC    = 2,
   parameter int NUM_OUT   = 2,
   parameter int CNT_W     = 4,
   parameter int MODE      = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [NUM_PORTS*NUM_VC*DATA_W-1:0]  data_in,
   input  logic [NUM_PORTS*NUM_VC-1:0]         empty,
   input  logic [NUM_OUT-1:0]                  out_full,
   output logic [NUM_PORTS*NUM_VC-1:0]         pop,
   output logic [NUM_OUT*DATA_W-1:0]           data_out,
   output logic [NUM_OUT-1:0]                  valid_out,
   output logic [NUM_OUT*CNT_W-1:0]            pkt_count,
   output logic [1:0]                          state
);
   localparam int NS     = NUM_PORTS * NUM_VC;
   localparam int DEST_W = $clog2(NUM_OUT);
   localparam int SW     = (NS > 1) ? $clog2(NS) : 1;
   localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int VW     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACTIVE = 2'b01,
      ST_STALL  = 2'b10
   } state_t;

   logic [NS-1:0][DATA_W-1:0]      words;
   logic [NS-1:0][DEST_W-1:0]      dest;
   logic [NS-1:0]                  elig;

   logic                           gnt_vld;
   logic [SW-1:0]                  gnt_src;
   logic [PW-1:0]                  gnt_p;
   logic [VW-1:0]                  gnt_v;
   logic [DEST_W-1:0]              gnt_dest;

   logic [NUM_VC-1:0][PW-1:0]      rr_vc_q, rr_vc_d;
   logic [SW-1:0]                  rr_all_q, rr_all_d;
   logic [NUM_OUT-1:0][DATA_W-1:0] data_q, data_d;
   logic [NUM_OUT-1:0]             valid_q, valid_d;
   logic [NUM_OUT-1:0][CNT_W-1:0]  cnt_q, cnt_d;
   state_t                         state_q, state_d;

   assign words = data_in;

   for (genvar s = 0; s < NS; s++) begin : g_src
      assign dest[s] = words[s][DATA_W-1 -: DEST_W];
      assign elig[s] = ~empty[s] & ~out_full[dest[s]];
   end

   // First eligible source found scanning forward from the relevant pointer wins.
   always_comb begin
      int p;
      int s;
      p       = 0;
      s       = 0;
      gnt_vld = 1'b0;
      gnt_src = '0;
      gnt_p   = '0;
      gnt_v   = '0;
      if (MODE == 0) begin
         for (int v = 0; v < NUM_VC; v++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
               p = (int'(rr_vc_q[VW'(v)]) + k) % NUM_PORTS;
               s = p * NUM_VC + v;
               if (!gnt_vld && elig[SW'(s)]) begin
                  gnt_vld = 1'b1;
                  gnt_src = SW'(s);
                  gnt_p   = PW'(p);
                  gnt_v   = VW'(v);
               end
            end
         end
      end else begin
         for (int k = 0; k < NS; k++) begin
            s = (int'(rr_all_q) + k) % NS;
            if (!gnt_vld && elig[SW'(s)]) begin
               gnt_vld = 1'b1;
               gnt_src = SW'(s);
               gnt_p   = PW'(s / NUM_VC);
               gnt_v   = VW'(s % NUM_VC);
            end
         end
      end
      if (reset) gnt_vld = 1'b0;
   end

   assign gnt_dest = dest[gnt_src];
   assign pop      = gnt_vld ? (NS'(1) << gnt_src) : '0;

   always_comb begin
      data_d   = data_q;
      valid_d  = '0;
      cnt_d    = cnt_q;
      rr_vc_d  = rr_vc_q;
      rr_all_d = rr_all_q;
      if (gnt_vld) begin
         data_d[gnt_dest]  = words[gnt_src];
         valid_d[gnt_dest] = 1'b1;
         cnt_d[gnt_dest]   = cnt_q[gnt_dest] + CNT_W'(1);
         if (MODE == 0)
            rr_vc_d[gnt_v] = (int'(gnt_p) == NUM_PORTS - 1) ? '0 : gnt_p + PW'(1);
         else
            rr_all_d = (int'(gnt_src) == NS - 1) ? '0 : gnt_src + SW'(1);
      end
      if (&empty)       state_d = ST_IDLE;
      else if (gnt_vld) state_d = ST_ACTIVE;
      else              state_d = ST_STALL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q   <= '0;
         valid_q  <= '0;
         cnt_q    <= '0;
         rr_vc_q  <= '0;
         rr_all_q <= '0;
         state_q  <= ST_IDLE;
      end else begin
         data_q   <= data_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         rr_vc_q  <= rr_vc_d;
         rr_all_q <= rr_all_d;
         state_q  <= state_d;
      end
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign pkt_count = cnt_q;
   assign state     = state_q;

endmodule
